ask_two_mod: RTL and testbench

//   2-ASK (on-off keying) modulator, the transmit side of the 2-ASK demodulator.

---
 rtl/ask_two_mod.sv | 121 ++++++++++++
 tb/tb_ask_two_mod.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ask_two_mod.sv
// 2-ASK (on-off keying) modulator: parallel words in over valid/ready, serialised MSB first onto y.
// Handshake in cycle T puts the first symbol on y in T+1; din_ready is high in IDLE and on a word's final clock.
module ask_two_mod #(
  parameter int DW       = 8,
  parameter int SYM_CLKS = 8,
  parameter int CAR_HALF = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          y,
  output logic          bit_out,
  output logic          sym_start,
  output logic          busy
);

  localparam int SW = $clog2(SYM_CLKS);
  localparam int BW = $clog2(DW);
  localparam int CW = $clog2(CAR_HALF) + 1;

  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_CLKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [CW-1:0] CAR_LAST = CW'(2 * CAR_HALF - 1);
  localparam logic [CW-1:0] CAR_MID  = CW'(CAR_HALF);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [SW-1:0] sym_cnt_q, sym_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] car_cnt_q, car_cnt_d;
  logic          y_q, y_d;
  logic          bit_out_q, bit_out_d;
  logic          sym_start_q, sym_start_d;
  logic          busy_q, busy_d;
  logic          word_end;
  logic          hs;
  logic          on_air;

  // The registers always describe the cycle currently on air, so outputs are
  // computed from next-state values and land aligned with the state they show.
  assign word_end  = (state_q == SEND) && (sym_cnt_q == SYM_LAST) && (bit_cnt_q == BIT_LAST);
  assign din_ready = reset && ((state_q == IDLE) || word_end);
  assign hs        = din_valid && din_ready;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    sym_cnt_d = sym_cnt_q;
    bit_cnt_d = bit_cnt_q;
    car_cnt_d = car_cnt_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          shift_d   = din;
          sym_cnt_d = '0;
          bit_cnt_d = '0;
          car_cnt_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (sym_cnt_q == SYM_LAST) begin
          sym_cnt_d = '0;
          car_cnt_d = '0;
          shift_d   = {shift_q[DW-2:0], 1'b0};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (hs) shift_d = din;
            else    state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SW'(1);
          car_cnt_d = (car_cnt_q == CAR_LAST) ? '0 : car_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    on_air      = (state_d == SEND);
    bit_out_d   = on_air && shift_d[DW-1];
    y_d         = bit_out_d && (car_cnt_d >= CAR_MID);
    sym_start_d = on_air && (sym_cnt_d == '0);
    busy_d      = on_air;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      sym_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      car_cnt_q   <= '0;
      y_q         <= 1'b0;
      bit_out_q   <= 1'b0;
      sym_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      sym_cnt_q   <= sym_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      car_cnt_q   <= car_cnt_d;
      y_q         <= y_d;
      bit_out_q   <= bit_out_d;
      sym_start_q <= sym_start_d;
      busy_q      <= busy_d;
    end
  end

  assign y         = y_q;
  assign bit_out   = bit_out_q;
  assign sym_start = sym_start_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ask_two_mod.sv
// Bench for ask_two_mod: three instances (defaults, CAR_HALF=2, DW=4) with a queue-based scoreboard.
module tb_ask_two_mod;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din0, din1;
  logic [3:0] din2;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic       y0, y1, y2;
  logic       bo0, bo1, bo2;
  logic       ss0, ss1, ss2;
  logic       busy0, busy1, busy2;

  int checks   = 0;
  int failures = 0;

  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [2:0] q2[$];

  always #5 clk = ~clk;

  ask_two_mod #(.DW(8), .SYM_CLKS(8), .CAR_HALF(1)) u0 (
    .clk(clk), .reset(reset), .din(din0), .din_valid(v0), .din_ready(r0),
    .y(y0), .bit_out(bo0), .sym_start(ss0), .busy(busy0));

  ask_two_mod #(.DW(8), .SYM_CLKS(8), .CAR_HALF(2)) u1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(v1), .din_ready(r1),
    .y(y1), .bit_out(bo1), .sym_start(ss1), .busy(busy1));

  ask_two_mod #(.DW(4), .SYM_CLKS(8), .CAR_HALF(1)) u2 (
    .clk(clk), .reset(reset), .din(din2), .din_valid(v2), .din_ready(r2),
    .y(y2), .bit_out(bo2), .sym_start(ss2), .busy(busy2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic rdy_of(input int idx);
    case (idx)
      0:       return r0;
      1:       return r1;
      default: return r2;
    endcase
  endfunction

  function automatic logic busy_of(input int idx);
    case (idx)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Expected {y, bit_out, sym_start} per clock, 8 clocks per symbol, MSB first.
  task automatic push_exp(input int idx, input logic [7:0] w, input int dw, input int ch);
    logic [2:0] e;
    logic       b;
    for (int i = dw - 1; i >= 0; i--) begin
      b = w[i];
      for (int k = 0; k < 8; k++) begin
        e = {b & (((k / ch) % 2) == 1), b, (k == 0)};
        case (idx)
          0:       q0.push_back(e);
          1:       q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
    end
  endtask

  task automatic mon(input int idx, input logic [2:0] obs, input logic bsy);
    logic [2:0] e;
    if (bsy) begin
      if (qsize(idx) == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output inst=%0d actual=%0b required=none at %0t", idx, obs, $time);
      end else begin
        case (idx)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        check($sformatf("stream%0d_y_bit_sym", idx), {29'd0, obs}, {29'd0, e});
      end
    end else begin
      check($sformatf("idle%0d_y", idx), {31'd0, obs[2]}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, {y0, bo0, ss0}, busy0);
    mon(1, {y1, bo1, ss1}, busy1);
    mon(2, {y2, bo2, ss2}, busy2);
  end

  task automatic send(input int idx, input logic [7:0] w, input bit hold);
    int n = 0;
    case (idx)
      0:       begin din0 = w;      v0 = 1'b1; end
      1:       begin din1 = w;      v1 = 1'b1; end
      default: begin din2 = w[3:0]; v2 = 1'b1; end
    endcase
    while (!rdy_of(idx) && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    if (!rdy_of(idx)) begin
      checks++;
      failures++;
      $display("FAIL send_timeout inst=%0d actual=not_ready required=ready", idx);
    end else begin
      case (idx)
        0:       push_exp(0, w, 8, 1);
        1:       push_exp(1, w, 8, 2);
        default: push_exp(2, w, 4, 1);
      endcase
    end
    @(posedge clk); #1;
    if (!hold) begin
      case (idx)
        0:       v0 = 1'b0;
        1:       v1 = 1'b0;
        default: v2 = 1'b0;
      endcase
    end
  endtask

  task automatic wait_idle(input int idx);
    int n = 0;
    while ((qsize(idx) != 0 || busy_of(idx)) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check($sformatf("drain%0d", idx), {31'd0, (qsize(idx) == 0) && !busy_of(idx)}, 32'd1);
  endtask

  initial begin
    int  n;
    int  m;
    bit  gap;
    reset = 1'b0;
    din0 = 8'hA5; din1 = 8'h00; din2 = 4'h0;
    v0 = 1'b1; v1 = 1'b0; v2 = 1'b0;

    // Reset held with din_valid asserted
    repeat (3) @(negedge clk);
    #1;
    check("rst_y",     {31'd0, y0},    32'd0);
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_ready", {31'd0, r0},    32'd0);
    check("rst_ready_inst1", {31'd0, r1}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_after_release", {31'd0, r0}, 32'd1);

    // Single word A5
    send(0, 8'hA5, 1'b0);
    wait_idle(0);
    check("a5_end_y",    {31'd0, y0},    32'd0);
    check("a5_end_busy", {31'd0, busy0}, 32'd0);

    // Back-to-back FF then 00 with din_valid held
    send(0, 8'hFF, 1'b1);
    din0 = 8'h00;
    n = 0;
    gap = 1'b0;
    do begin
      @(negedge clk); #1;
      n++;
      if (!busy0) gap = 1'b1;
    end while (!r0 && n < 200);
    check("b2b_ready_cycle", n, 32'd64);
    check("b2b_busy_gap_first", {31'd0, gap}, 32'd0);
    if (r0) push_exp(0, 8'h00, 8, 1);
    @(posedge clk); #1;
    v0 = 1'b0;
    m = 0;
    @(negedge clk); #1;
    while (busy0 && m < 200) begin
      m++;
      @(negedge clk); #1;
    end
    check("b2b_second_word_busy_clocks", m, 32'd64);
    wait_idle(0);

    // Reset in the middle of word FF
    send(0, 8'hFF, 1'b0);
    repeat (19) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_y",       {31'd0, y0},    32'd0);
    check("abort_busy",    {31'd0, busy0}, 32'd0);
    check("abort_bit_out", {31'd0, bo0},   32'd0);
    check("abort_ready",   {31'd0, r0},    32'd0);
    q0.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_after_abort", {31'd0, r0}, 32'd1);
    send(0, 8'h80, 1'b0);
    wait_idle(0);

    // Carrier half-period of 2 clocks
    send(1, 8'hC0, 1'b0);
    wait_idle(1);

    // Four-bit words
    send(2, 8'h09, 1'b0);
    wait_idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
